mc_cpu: RTL and testbench

MC_CPU -- requirements
Module: mc_cpu

---
 rtl/mc_cpu_pkg.sv | 46 ++++
 rtl/mc_cpu_alu.sv | 44 ++++
 rtl/mc_cpu.sv | 139 +++++++++++++
 tb/tb_mc_cpu.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_cpu_pkg.sv
// Shared types for the mc_cpu multi-cycle core.
// Holds opcodes, FSM states, branch condition codes and the flag bundle.
package mc_cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_XOR  = 4'h2, OP_RSV3 = 4'h3,
    OP_SLL  = 4'h4, OP_SRA  = 4'h5, OP_ROR  = 4'h6, OP_RSV7 = 4'h7,
    OP_LW   = 4'h8, OP_SW   = 4'h9, OP_LLB  = 4'hA, OP_LHB  = 4'hB,
    OP_B    = 4'hC, OP_RSVD = 4'hD, OP_RSVE = 4'hE, OP_HLT  = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [2:0] CC_NE = 3'd0;
  localparam logic [2:0] CC_EQ = 3'd1;
  localparam logic [2:0] CC_GT = 3'd2;
  localparam logic [2:0] CC_LT = 3'd3;
  localparam logic [2:0] CC_GE = 3'd4;
  localparam logic [2:0] CC_LE = 3'd5;
  localparam logic [2:0] CC_OV = 3'd6;
  localparam logic [2:0] CC_AL = 3'd7;

  typedef struct packed {
    logic z;
    logic v;
    logic n;
  } flags_t;

  function automatic logic branch_taken(input logic [2:0] cond, input flags_t f);
    logic t;
    case (cond)
      CC_NE:   t = !f.z;
      CC_EQ:   t = f.z;
      CC_GT:   t = !f.z && !f.n;
      CC_LT:   t = f.n;
      CC_GE:   t = f.z || !f.n;
      CC_LE:   t = f.n || f.z;
      CC_OV:   t = f.v;
      default: t = 1'b1;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mc_cpu_alu.sv
// Combinational ALU for mc_cpu: saturating add/sub, xor, shifts, rotate.
// Produces Z/V/N; the core decides which flags an opcode actually updates.
module mc_cpu_alu
  import mc_cpu_pkg::*;
#(
  parameter int DW = 16
) (
  input  opcode_t       op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    shamt,
  output logic [DW-1:0] y,
  output flags_t        flags
);

  logic          is_sub;
  logic          ovf;
  logic [DW-1:0] b_eff;
  logic [DW-1:0] sum;
  logic [DW-1:0] sat;

  always_comb begin
    is_sub = (op == OP_SUB);
    b_eff  = is_sub ? ~b : b;
    sum    = a + b_eff + {{(DW-1){1'b0}}, is_sub};
    // Overflow only when both addends share a sign the result lost; clamp toward a's sign.
    ovf    = (a[DW-1] == b_eff[DW-1]) && (sum[DW-1] != a[DW-1]);
    sat    = ovf ? {a[DW-1], {(DW-1){~a[DW-1]}}} : sum;

    case (op)
      OP_ADD, OP_SUB: y = sat;
      OP_XOR:         y = a ^ b;
      OP_SLL:         y = a << shamt;
      OP_SRA:         y = $signed(a) >>> shamt;
      OP_ROR:         y = (a >> shamt) | (a << (7'(DW) - 7'(shamt)));
      default:        y = a;
    endcase

    flags.z = (y == '0);
    flags.n = y[DW-1];
    flags.v = ovf && (op == OP_ADD || op == OP_SUB);
  end

endmodule

// File: rtl/mc_cpu.sv
// Multi-cycle 16-bit-ISA core with a unified instruction/data memory port.
// FSM, register file and PC live here; arithmetic is in mc_cpu_alu.
module mc_cpu
  import mc_cpu_pkg::*;
#(
  parameter int            DW       = 16,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          hlt,
  output logic [DW-1:0] pc,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  state_t        state, state_nx;
  logic [15:0]   ir;
  logic [DW-1:0] regs [16];
  logic [DW-1:0] op_a, op_b, op_d;
  logic [DW-1:0] result, ea;
  flags_t        flags;

  opcode_t       op;
  logic [3:0]    rd;
  logic [DW-1:0] pc_seq, br_target, ea_nx, merged, alu_y;
  flags_t        alu_flags;

  always_comb begin
    op        = opcode_t'(ir[15:12]);
    rd        = ir[11:8];
    pc_seq    = pc + DW'(2);
    br_target = pc_seq + {{(DW-10){ir[8]}}, ir[8:0], 1'b0};
    ea_nx     = op_a + {{(DW-5){ir[3]}}, ir[3:0], 1'b0};
    merged    = op_d;
    if (op == OP_LLB) merged[7:0]  = ir[7:0];
    else              merged[15:8] = ir[7:0];
  end

  mc_cpu_alu #(.DW(DW)) u_alu (
    .op    (op),
    .a     (op_a),
    .b     (op_b),
    .shamt (ir[3:0]),
    .y     (alu_y),
    .flags (alu_flags)
  );

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {pc[DW-1:1], 1'b0};
    mem_wdata = op_d;
    hlt       = (state == S_HALT);
    case (state)
      S_RST:    state_nx = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) state_nx = S_DECODE;
      end
      S_DECODE: state_nx = (op == OP_HLT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR,
          OP_LLB, OP_LHB:  state_nx = S_WB;
          OP_LW, OP_SW:    state_nx = S_MEM;
          default:         state_nx = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (op == OP_SW);
        mem_addr = ea;
        if (mem_ack) state_nx = (op == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:     state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_RST;
      pc     <= RESET_PC;
      ir     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_d   <= '0;
      result <= '0;
      ea     <= '0;
      flags  <= '0;
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_FETCH: if (mem_ack) ir <= mem_rdata[15:0];
        S_DECODE: begin
          op_a <= regs[ir[7:4]];
          op_b <= regs[ir[3:0]];
          op_d <= regs[rd];
        end
        S_EXEC: begin
          case (op)
            OP_ADD, OP_SUB: begin
              result <= alu_y;
              flags  <= alu_flags;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
              result  <= alu_y;
              flags.z <= alu_flags.z;
            end
            OP_LLB, OP_LHB: result <= merged;
            OP_LW, OP_SW:   ea <= ea_nx & {{(DW-1){1'b1}}, 1'b0};
            OP_B:           pc <= branch_taken(ir[11:9], flags) ? br_target : pc_seq;
            default:        pc <= pc_seq;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            if (op == OP_LW) result <= mem_rdata;
            else             pc     <= pc_seq;
          end
        end
        S_WB: begin
          if (rd != 4'd0) regs[rd] <= result;
          pc <= pc_seq;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cpu.sv
// Self-checking bench for mc_cpu: an instruction-level reference model steps
// alongside the core, checking every memory access, pc and instruction timing.
module tb_mc_cpu;

  localparam int          DW     = 16;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hlt, mem_req, mem_we;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] pc, mem_addr, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mc_cpu #(.DW(DW), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hlt       (hlt),
    .pc        (pc),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] mem [256];
  logic [15:0] mreg [16];
  logic        mz, mv, mn;
  logic [15:0] mpc;
  int unsigned rel_cyc;
  int          wait_mode;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick_wait();
    return (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
  endfunction

  // Called at a negedge with mem_req high; holds ack low for 'waits' cycles.
  task automatic serve(input int waits);
    logic [15:0] a, d;
    logic        we;
    a  = mem_addr;
    d  = mem_wdata;
    we = mem_we;
    for (int i = 0; i < waits; i++) begin
      mem_ack = 1'b0;
      @(negedge clk);
      check("req_held", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, we, a, d});
    end
    mem_ack   = 1'b1;
    mem_rdata = mem[a[8:1]];
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic wait_req(input logic [15:0] hold_pc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (mem_req) ok = 1'b1;
      else begin
        check("pc_hold", pc, hold_pc);
        @(negedge clk);
      end
    end
    if (!ok) check("req_timeout", mem_req, 1'b1);
  endtask

  task automatic do_reset();
    mem_ack = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 1'b0);
    check("rst_hlt", hlt, 1'b0);
    check("rst_pc", pc, RST_PC);
    rst_n   = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic run_prog(input int max_instr);
    logic [15:0] ins, a, b, d, r, ea, nxt, prev_pc;
    logic [3:0]  opc, rd, rs, rt;
    int          s, o, w, exp_cyc;
    int unsigned t0;
    bit          ok, first, done, halted, wr, tk;
    for (int i = 0; i < 16; i++) mreg[i] = 16'd0;
    mz = 1'b0; mv = 1'b0; mn = 1'b0;
    mpc = RST_PC; prev_pc = RST_PC;
    first = 1'b1; done = 1'b0; halted = 1'b0; exp_cyc = 0; t0 = 0;
    for (int n = 0; n < max_instr && !done; n++) begin
      wait_req(prev_pc, ok);
      if (!ok) done = 1'b1;
      else begin
        if (first) check("first_req_cycle", cyc - rel_cyc, 1);
        else       check("cycles_per_instr", cyc - t0, exp_cyc);
        first = 1'b0;
        t0    = cyc;
        check("fetch_addr", mem_addr, mpc);
        check("fetch_we", mem_we, 1'b0);
        check("fetch_pc", pc, mpc);
        ins = mem[mpc[8:1]];
        w   = pick_wait();
        serve(w);
        exp_cyc = w;
        opc = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
        a = mreg[rs]; b = mreg[rt]; d = mreg[rd];
        nxt = mpc + 16'd2;
        wr  = 1'b0;
        r   = 16'd0;
        case (opc)
          4'h0, 4'h1: begin
            s = (opc == 4'h0) ? int'($signed(a)) + int'($signed(b))
                              : int'($signed(a)) - int'($signed(b));
            mv = (s > 32767) || (s < -32768);
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            r  = s[15:0];
            mz = (r == 16'd0);
            mn = r[15];
            wr = 1'b1; exp_cyc += 4;
          end
          4'h2, 4'h4, 4'h5, 4'h6: begin
            if (opc == 4'h2)      r = a ^ b;
            else if (opc == 4'h4) r = a << rt;
            else if (opc == 4'h5) r = 16'(int'($signed(a)) >>> rt);
            else begin
              r = a;
              for (int k = 0; k < int'(rt); k++) r = {r[0], r[15:1]};
            end
            mz = (r == 16'd0);
            wr = 1'b1; exp_cyc += 4;
          end
          4'hA: begin r = {d[15:8], ins[7:0]}; wr = 1'b1; exp_cyc += 4; end
          4'hB: begin r = {ins[7:0], d[7:0]}; wr = 1'b1; exp_cyc += 4; end
          4'h8, 4'h9: begin
            o  = rt[3] ? int'(rt) - 16 : int'(rt);
            ea = 16'(int'(a) + 2 * o);
            ea[0] = 1'b0;
            wait_req(mpc, ok);
            if (!ok) done = 1'b1;
            else begin
              check("data_addr", mem_addr, ea);
              check("data_we", mem_we, opc == 4'h9);
              check("data_pc", pc, mpc);
              if (opc == 4'h9) check("data_wdata", mem_wdata, d);
              w = pick_wait();
              exp_cyc += w;
              if (opc == 4'h8) begin r = mem[ea[8:1]]; wr = 1'b1; exp_cyc += 5; end
              else exp_cyc += 4;
              serve(w);
              if (opc == 4'h9) mem[ea[8:1]] = d;
            end
          end
          4'hC: begin
            case (ins[11:9])
              3'd0:    tk = !mz;
              3'd1:    tk = mz;
              3'd2:    tk = !mz && !mn;
              3'd3:    tk = mn;
              3'd4:    tk = mz || !mn;
              3'd5:    tk = mn || mz;
              3'd6:    tk = mv;
              default: tk = 1'b1;
            endcase
            o = ins[8] ? int'(ins[8:0]) - 512 : int'(ins[8:0]);
            if (tk) nxt = 16'(int'(mpc) + 2 + 2 * o);
            exp_cyc += 3;
          end
          4'hF: begin
            check("hlt_decode", hlt, 1'b0);
            @(negedge clk);
            check("hlt", hlt, 1'b1);
            check("hlt_pc", pc, mpc);
            for (int i = 0; i < 20; i++) begin
              @(negedge clk);
              check("halt_quiet", {hlt, mem_req, pc}, {1'b1, 1'b0, mpc});
            end
            for (int i = 0; i < 16; i++) check($sformatf("reg%0d", i), dut.regs[i], mreg[i]);
            check("flags", {dut.flags.z, dut.flags.v, dut.flags.n}, {mz, mv, mn});
            halted = 1'b1;
            done   = 1'b1;
          end
          default: exp_cyc += 3;
        endcase
        if (!done) begin
          if (wr && rd != 4'd0) mreg[rd] = r;
          prev_pc = mpc;
          mpc     = nxt;
        end
      end
    end
    check("halted", halted, 1'b1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  // Saturating add, store/load through address 2, and flag-driven branches.
  task automatic load_prog_a();
    clear_mem();
    mem[0] = 16'hA17F; mem[1] = 16'hB17F; mem[2] = 16'h0211; mem[3] = 16'h9201;
    mem[4] = 16'h8301; mem[5] = 16'h2610; mem[6] = 16'h1411; mem[7] = 16'hC1FE;
    mem[8] = 16'h2661; mem[9] = 16'hC3FE; mem[10] = 16'hF000;
  endtask

  task automatic load_random(input int n);
    logic [3:0]  alu_ops [6];
    logic [3:0]  rsv_ops [4];
    logic [3:0]  rd, rs, rt;
    logic [7:0]  imm8;
    logic [2:0]  cond;
    logic [8:0]  off9;
    logic [15:0] ins;
    int          k;
    alu_ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6};
    rsv_ops = '{4'h3, 4'h7, 4'hD, 4'hE};
    clear_mem();
    for (int i = 8'h78; i <= 8'h87; i++) mem[i] = 16'($urandom);
    mem[0] = 16'hAF00;
    mem[1] = 16'hBF01;
    for (int i = 0; i < n; i++) begin
      k    = $urandom_range(0, 9);
      rd   = 4'($urandom_range(0, 14));
      rs   = 4'($urandom_range(0, 15));
      rt   = 4'($urandom);
      imm8 = 8'($urandom);
      cond = 3'($urandom);
      off9 = 9'($urandom_range(0, 3));
      case (k)
        0, 1, 2: ins = {alu_ops[$urandom_range(0, 5)], rd, rs, rt};
        3:       ins = {rsv_ops[$urandom_range(0, 3)], rd, rs, rt};
        4, 9:    ins = {4'hA, rd, imm8};
        5:       ins = {4'hB, rd, imm8};
        6:       ins = {4'h8, rd, 4'hF, rt};
        7:       ins = {4'h9, rd, 4'hF, rt};
        default: ins = {4'hC, cond, off9};
      endcase
      mem[2 + i] = ins;
    end
  endtask

  initial begin
    bit ok;

    wait_mode = 0; load_prog_a(); do_reset(); run_prog(64);
    wait_mode = 3; load_prog_a(); do_reset(); run_prog(64);

    wait_mode = 0;
    clear_mem();
    for (int i = 0; i < 8; i++) mem[i] = 16'h3000;
    do_reset(); run_prog(32);

    // Reset lands while the LW data access is still waiting for ack.
    clear_mem();
    mem[0] = 16'h8302; mem[1] = 16'hF000; mem[2] = 16'h1234;
    do_reset();
    wait_req(RST_PC, ok);
    serve(0);
    wait_req(RST_PC, ok);
    check("lw_pending_addr", mem_addr, 16'h0004);
    mem_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_drops_req", mem_req, 1'b0);
    check("rst_lw_dest", dut.regs[3], 16'h0000);
    check("rst_mid_pc", pc, RST_PC);
    @(negedge clk);
    do_reset(); run_prog(8);

    for (int p = 0; p < 8; p++) begin
      wait_mode = -1;
      load_random(40);
      do_reset();
      run_prog(200);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
